// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Central stall/flush controller for the 5-stage rv32i pipeline. Arbitrates the
// D-cache wait, EX branch/jump redirect, load-use hazard and I-cache wait into
// PC/stage-register enables, bubble inserts and the PC source select. A redirect
// that arrives while an I-cache fetch is in flight is parked in saved_target
// until the fetch completes, so the fetch address stays stable.
//
// Parameters
//   CNT_W           width of each saturating performance counter
// Ports
//   clk             clock
//   rst             asynchronous reset, active-low
//   load_RAW_stall  load-use hazard from the EX forwarding unit
//   ex_redirect     EX resolved a taken branch/jump this cycle
//   ex_target       redirect target PC from EX
//   icache_read     IF has a fetch request asserted
//   icache_resp     I-cache response valid this cycle
//   dcache_req      MEM has a load/store asserted
//   dcache_resp     D-cache response valid this cycle
//   load_pc         PC register enable
//   pc_sel          0 = pc+4, 1 = ex_target, 2 = saved_target
//   saved_target    parked redirect target
//   load_*          stage register enables (IF/ID, ID/EX, EX/MEM, MEM/WB)
//   flush_*         load a bubble into IF/ID, ID/EX, EX/MEM
//   stall_cycles    cycles with load_pc=0 in RUN plus every REDIR_PEND cycle
//   flush_count     number of accepted redirects
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_RAW_stall,
    input  logic             ex_redirect,
    input  logic [31:0]      ex_target,
    input  logic             icache_read,
    input  logic             icache_resp,
    input  logic             dcache_req,
    input  logic             dcache_resp,
    output logic             load_pc,
    output logic [1:0]       pc_sel,
    output logic [31:0]      saved_target,
    output logic             load_if_id,
    output logic             load_id_ex,
    output logic             load_ex_mem,
    output logic             load_mem_wb,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             flush_ex_mem,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [0:0] {
        ST_RUN        = 1'b0,
        ST_REDIR_PEND = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Saturating increment: an all-ones counter holds its value.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : (v + CNT_ONE);
    endfunction

    state_t            state_r;
    state_t            state_nxt_s;
    logic [31:0]       saved_target_r;
    logic [CNT_W-1:0]  stall_cnt_r;
    logic [CNT_W-1:0]  flush_cnt_r;
    logic              save_en_s;
    logic              stall_inc_s;
    logic              flush_inc_s;
    logic              mem_stall_s;
    logic              if_stall_s;

    // A response in the same cycle as the request clears the wait.
    assign mem_stall_s  = dcache_req  & ~dcache_resp;
    assign if_stall_s   = icache_read & ~icache_resp;

    assign saved_target = saved_target_r;
    assign stall_cycles = stall_cnt_r;
    assign flush_count  = flush_cnt_r;

    // Hazard arbitration: next state, enables, bubbles, PC select, counter strobes.
    always_comb begin
        state_nxt_s  = state_r;
        load_pc      = 1'b0;
        pc_sel       = 2'd0;
        load_if_id   = 1'b0;
        load_id_ex   = 1'b0;
        load_ex_mem  = 1'b0;
        load_mem_wb  = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_ex_mem = 1'b0;
        save_en_s    = 1'b0;
        stall_inc_s  = 1'b0;
        flush_inc_s  = 1'b0;
        if (!rst) begin
            state_nxt_s = ST_RUN;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (mem_stall_s) begin
                        // Whole pipe frozen; EX re-presents any redirect next cycle.
                        stall_inc_s = 1'b1;
                    end else if (ex_redirect && !if_stall_s) begin
                        // Redirect beats load-use: the consumer in EX still completes.
                        load_pc     = 1'b1;
                        pc_sel      = 2'd1;
                        load_if_id  = 1'b1;
                        load_id_ex  = 1'b1;
                        load_ex_mem = 1'b1;
                        load_mem_wb = 1'b1;
                        flush_if_id = 1'b1;
                        flush_id_ex = 1'b1;
                        flush_inc_s = 1'b1;
                    end else if (ex_redirect) begin
                        // Fetch in flight: park the target, keep the fetch address.
                        load_id_ex  = 1'b1;
                        flush_id_ex = 1'b1;
                        load_ex_mem = 1'b1;
                        load_mem_wb = 1'b1;
                        save_en_s   = 1'b1;
                        state_nxt_s = ST_REDIR_PEND;
                        flush_inc_s = 1'b1;
                        stall_inc_s = 1'b1;
                    end else if (load_RAW_stall) begin
                        load_ex_mem  = 1'b1;
                        flush_ex_mem = 1'b1;
                        load_mem_wb  = 1'b1;
                        stall_inc_s  = 1'b1;
                    end else if (if_stall_s) begin
                        load_id_ex  = 1'b1;
                        flush_id_ex = 1'b1;
                        load_ex_mem = 1'b1;
                        load_mem_wb = 1'b1;
                        stall_inc_s = 1'b1;
                    end else begin
                        load_pc     = 1'b1;
                        load_if_id  = 1'b1;
                        load_id_ex  = 1'b1;
                        load_ex_mem = 1'b1;
                        load_mem_wb = 1'b1;
                    end
                end
                ST_REDIR_PEND: begin
                    // Every pending cycle counts as a stall; EX holds a bubble here.
                    stall_inc_s = 1'b1;
                    if (mem_stall_s) begin
                        state_nxt_s = ST_REDIR_PEND;
                    end else if (!icache_resp) begin
                        load_id_ex  = 1'b1;
                        flush_id_ex = 1'b1;
                        load_ex_mem = 1'b1;
                        load_mem_wb = 1'b1;
                    end else begin
                        // Fetched word is on the wrong path: drop it, jump to parked target.
                        load_pc     = 1'b1;
                        pc_sel      = 2'd2;
                        load_if_id  = 1'b1;
                        flush_if_id = 1'b1;
                        load_id_ex  = 1'b1;
                        flush_id_ex = 1'b1;
                        load_ex_mem = 1'b1;
                        load_mem_wb = 1'b1;
                        state_nxt_s = ST_RUN;
                    end
                end
                default: begin
                    state_nxt_s = ST_RUN;
                end
            endcase
        end
    end

    // State, parked target and saturating counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r        <= ST_RUN;
            saved_target_r <= 32'd0;
            stall_cnt_r    <= {CNT_W{1'b0}};
            flush_cnt_r    <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (save_en_s) begin
                saved_target_r <= ex_target;
            end
            if (stall_inc_s) begin
                stall_cnt_r <= sat_inc(stall_cnt_r);
            end
            if (flush_inc_s) begin
                flush_cnt_r <= sat_inc(flush_cnt_r);
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Directed scenarios followed by randomized traffic, checked against a
// stage-action reference model. A second instance with CNT_W=4 exercises
// counter saturation with the same stimulus.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam int HOLD = 0;
    localparam int ADV  = 1;
    localparam int BUB  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load_RAW_stall = 1'b0;
    logic        ex_redirect = 1'b0;
    logic [31:0] ex_target = 32'd0;
    logic        icache_read = 1'b0;
    logic        icache_resp = 1'b0;
    logic        dcache_req = 1'b0;
    logic        dcache_resp = 1'b0;

    logic        load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
    logic        flush_if_id, flush_id_ex, flush_ex_mem;
    logic [1:0]  pc_sel;
    logic [31:0] saved_target, stall_cycles, flush_count;

    logic        d4_load_pc, d4_load_if_id, d4_load_id_ex, d4_load_ex_mem, d4_load_mem_wb;
    logic        d4_flush_if_id, d4_flush_id_ex, d4_flush_ex_mem;
    logic [1:0]  d4_pc_sel;
    logic [31:0] d4_saved_target;
    logic [3:0]  d4_stall_cycles, d4_flush_count;

    int          n_cmp = 0;
    int          n_err = 0;

    bit          m_pend;
    logic [31:0] m_saved;
    longint      m_stall;
    longint      m_flush;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk(clk), .rst(rst), .load_RAW_stall(load_RAW_stall), .ex_redirect(ex_redirect),
        .ex_target(ex_target), .icache_read(icache_read), .icache_resp(icache_resp),
        .dcache_req(dcache_req), .dcache_resp(dcache_resp), .load_pc(load_pc),
        .pc_sel(pc_sel), .saved_target(saved_target), .load_if_id(load_if_id),
        .load_id_ex(load_id_ex), .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    hazard_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .load_RAW_stall(load_RAW_stall), .ex_redirect(ex_redirect),
        .ex_target(ex_target), .icache_read(icache_read), .icache_resp(icache_resp),
        .dcache_req(dcache_req), .dcache_resp(dcache_resp), .load_pc(d4_load_pc),
        .pc_sel(d4_pc_sel), .saved_target(d4_saved_target), .load_if_id(d4_load_if_id),
        .load_id_ex(d4_load_id_ex), .load_ex_mem(d4_load_ex_mem), .load_mem_wb(d4_load_mem_wb),
        .flush_if_id(d4_flush_if_id), .flush_id_ex(d4_flush_id_ex), .flush_ex_mem(d4_flush_ex_mem),
        .stall_cycles(d4_stall_cycles), .flush_count(d4_flush_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [31:0] sat(input longint v, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        if (v > mx) return mx[31:0];
        return v[31:0];
    endfunction

    function automatic logic [31:0] obs_load();
        return {27'd0, load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb};
    endfunction

    function automatic logic [31:0] obs_flush();
        return {29'd0, flush_if_id, flush_id_ex, flush_ex_mem};
    endfunction

    task automatic chk_counters(input string tag);
        chk({tag, "_saved"}, saved_target, m_saved);
        chk({tag, "_stall"}, stall_cycles, sat(m_stall, 32));
        chk({tag, "_flush"}, flush_count, sat(m_flush, 32));
        chk({tag, "_stall4"}, {28'd0, d4_stall_cycles}, sat(m_stall, 4));
        chk({tag, "_flush4"}, {28'd0, d4_flush_count}, sat(m_flush, 4));
    endtask

    // Called at posedge+1; pulses rst low for one edge and checks the reset view.
    task automatic reset_dut();
        rst = 1'b0;
        #1;
        m_pend  = 1'b0;
        m_saved = 32'd0;
        m_stall = 0;
        m_flush = 0;
        chk("rst_load", obs_load(), 32'd0);
        chk("rst_flush", obs_flush(), 32'd0);
        chk("rst_pcsel", {30'd0, pc_sel}, 32'd0);
        chk_counters("rst");
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // One pipeline cycle: drive inputs at posedge+1, check at posedge+2, advance.
    task automatic cyc(input bit raw, input bit red, input logic [31:0] tgt,
                       input bit ir, input bit irs, input bit dq, input bit drs);
        int          act [5];
        logic [1:0]  sel;
        bit          nxt_pend;
        logic [31:0] nxt_saved;
        bit          mem, ifs, add_flush, add_stall;
        logic [31:0] e_load, e_flush;
        load_RAW_stall = raw;
        ex_redirect    = red;
        ex_target      = tgt;
        icache_read    = ir;
        icache_resp    = irs;
        dcache_req     = dq;
        dcache_resp    = drs;
        #1;
        mem = dq && !drs;
        ifs = ir && !irs;
        for (int i = 0; i < 5; i++) act[i] = ADV;
        sel = 2'd0;
        nxt_pend  = m_pend;
        nxt_saved = m_saved;
        add_flush = 1'b0;
        if (mem) begin
            for (int i = 0; i < 5; i++) act[i] = HOLD;
        end else if (m_pend) begin
            act[2] = BUB;
            if (irs) begin
                sel = 2'd2;
                act[1] = BUB;
                nxt_pend = 1'b0;
            end else begin
                act[0] = HOLD;
                act[1] = HOLD;
            end
        end else if (red) begin
            act[1] = BUB;
            act[2] = BUB;
            add_flush = 1'b1;
            if (ifs) begin
                act[0] = HOLD;
                act[1] = HOLD;
                nxt_pend = 1'b1;
                nxt_saved = tgt;
            end else begin
                sel = 2'd1;
            end
        end else if (raw) begin
            act[0] = HOLD;
            act[1] = HOLD;
            act[2] = HOLD;
            act[3] = BUB;
        end else if (ifs) begin
            act[0] = HOLD;
            act[1] = HOLD;
            act[2] = BUB;
        end
        add_stall = m_pend || (act[0] == HOLD);
        e_load  = 32'd0;
        e_flush = 32'd0;
        for (int i = 0; i < 5; i++) e_load[4-i] = (act[i] != HOLD);
        for (int i = 0; i < 3; i++) e_flush[2-i] = (act[i+1] == BUB);
        chk("load", obs_load(), e_load);
        chk("flush", obs_flush(), e_flush);
        chk("pc_sel", {30'd0, pc_sel}, {30'd0, sel});
        chk_counters("cyc");
        @(posedge clk);
        #1;
        m_pend  = nxt_pend;
        m_saved = nxt_saved;
        if (add_stall) m_stall++;
        if (add_flush) m_flush++;
    endtask

    initial begin
        @(posedge clk);
        #1;
        reset_dut();

        // 1: free run
        repeat (10) cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("t1_stall", stall_cycles, 32'd0);
        chk("t1_flush", flush_count, 32'd0);

        // 2: single load-use bubble
        cyc(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("t2_stall", stall_cycles, 32'd1);

        // 3: redirect with fetch already answered
        reset_dut();
        cyc(1'b0, 1'b1, 32'h60, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("t3_flush", flush_count, 32'd1);

        // 4: redirect during an outstanding fetch
        reset_dut();
        cyc(1'b0, 1'b1, 32'h80, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) cyc(1'b0, 1'b1, 32'h44, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t4_saved", saved_target, 32'h80);
        chk("t4_stall", stall_cycles, 32'd4);
        cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("t4_flush", flush_count, 32'd1);

        // 5: D-cache wait masks redirect and load-use
        reset_dut();
        repeat (5) cyc(1'b1, 1'b1, 32'h44, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t5_stall", stall_cycles, 32'd5);
        chk("t5_flush0", flush_count, 32'd0);
        cyc(1'b1, 1'b1, 32'h44, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("t5_flush1", flush_count, 32'd1);

        // 6: saturation on the narrow instance, reset while pending
        reset_dut();
        repeat (20) cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t6_sat4", {28'd0, d4_stall_cycles}, 32'd15);
        chk("t6_stall32", stall_cycles, 32'd20);
        cyc(1'b0, 1'b1, 32'h9C, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        reset_dut();
        cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 96) == 0) begin
                reset_dut();
            end else begin
                cyc(($urandom % 4) == 0, ($urandom % 5) == 0, $urandom,
                    ($urandom % 4) != 0, ($urandom % 2) == 0,
                    ($urandom % 3) == 0, ($urandom % 2) == 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
